// File: rtl/pifo_headers.sv
// ============================================================================
//  Module      : pifo_headers (package)
//  Description : Shared types and helpers for the flow-level PIFO front end:
//                rank/priority, packet pointer, flow id and packet length
//                types, the default flow count and a saturating adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pifo_headers;

    localparam int NUM_FLOWS      = 64;
    localparam int PRIORITY_WIDTH = 16;
    localparam int LENGTH_WIDTH   = 11;
    localparam int POINTER_WIDTH  = 12;

    typedef logic [PRIORITY_WIDTH-1:0]    Priority;
    typedef logic [POINTER_WIDTH-1:0]     PacketPointer;
    typedef logic [$clog2(NUM_FLOWS)-1:0] FlowId;
    typedef logic [LENGTH_WIDTH-1:0]      PacketLength;

    // Unsigned add that clamps to all-ones instead of wrapping.
    function automatic Priority sat_add(input Priority a, input Priority b);
        logic [PRIORITY_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PRIORITY_WIDTH] ? '1 : sum[PRIORITY_WIDTH-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/stfq_flow_table.sv
// ============================================================================
//  Module      : stfq_flow_table
//  Description : Per-flow state for the STFQ rank stage. Holds one last
//                finish tag per flow (and a 4-bit cost shift per flow when
//                FLOW_RANK_WEIGHT_EN is defined). One asynchronous read port
//                and one synchronous write port; everything clears to 0 on
//                the asynchronous reset.
//  Ports       : clk, reset           - clock, async active-high reset
//                i__rd_flow_id        - flow being ranked
//                o__rd_finish         - its last finish tag
//                i__wr_en/flow/finish - finish tag update
//                i__weight_* / o__rd_weight - weight table (macro only)
//  Macro       : FLOW_RANK_WEIGHT_EN enables the weight table
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stfq_flow_table #(
    parameter int NUM_FLOWS      = 64,
    parameter int PRIORITY_WIDTH = 16,
    parameter int FLOW_WIDTH     = $clog2(NUM_FLOWS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FLOW_WIDTH-1:0]     i__rd_flow_id,
    input  logic                      i__wr_en,
    input  logic [FLOW_WIDTH-1:0]     i__wr_flow_id,
    input  logic [PRIORITY_WIDTH-1:0] i__wr_finish,
`ifdef FLOW_RANK_WEIGHT_EN
    input  logic                      i__weight_wr,
    input  logic [FLOW_WIDTH-1:0]     i__weight_flow_id,
    input  logic [3:0]                i__weight_shift,
    output logic [3:0]                o__rd_weight,
`endif
    output logic [PRIORITY_WIDTH-1:0] o__rd_finish
);

    logic [PRIORITY_WIDTH-1:0] r_finish [NUM_FLOWS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                r_finish[i] <= '0;
            end
        end else if (i__wr_en) begin
            r_finish[i__wr_flow_id] <= i__wr_finish;
        end
    end

    assign o__rd_finish = r_finish[i__rd_flow_id];

`ifdef FLOW_RANK_WEIGHT_EN
    logic [3:0] r_weight [NUM_FLOWS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                r_weight[i] <= '0;
            end
        end else if (i__weight_wr) begin
            r_weight[i__weight_flow_id] <= i__weight_shift;
        end
    end

    // Read is combinational from the stored value, so a write landing in
    // the same cycle as a rank of that flow only affects later packets.
    assign o__rd_weight = r_weight[i__rd_flow_id];
`endif

endmodule

`default_nettype wire

// File: rtl/stfq_rank_calc.sv
// ============================================================================
//  Module      : stfq_rank_calc
//  Description : Start-time fair queueing rank stage in front of the flow
//                PIFO. A descriptor is captured in S1, ranked as it moves to
//                OUT (start = max(virtual_time, finish[flow]), finish[flow]
//                <= sat(start + cost)), and OUT is offered to the PIFO
//                enqueue port while the PIFO is not full. Virtual time
//                follows the largest priority the PIFO has dequeued.
//  Ports       : clk, reset                         - clock, async reset
//                i__pkt_valid/flow_id/length/pointer, o__pkt_ready
//                                                   - descriptor input
//                o__enqueue, o__enqueue_priority, o__packet_pointer,
//                i__pifo_full                       - PIFO enqueue side
//                i__dequeue_fire, i__dequeue_priority - PIFO dequeue report
//                o__virtual_time                    - current virtual time
//                i__weight_wr/flow_id/shift         - weights (macro only)
//  Macro       : FLOW_RANK_WEIGHT_EN - cost = length << weight[flow]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stfq_rank_calc
    import pifo_headers::PacketPointer;
#(
    parameter int NUM_FLOWS      = 64,
    parameter int PRIORITY_WIDTH = 16,
    parameter int LENGTH_WIDTH   = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i__pkt_valid,
    input  logic [$clog2(NUM_FLOWS)-1:0] i__pkt_flow_id,
    input  logic [LENGTH_WIDTH-1:0]      i__pkt_length,
    input  PacketPointer                 i__pkt_pointer,
    output logic                         o__pkt_ready,
    output logic                         o__enqueue,
    output logic [PRIORITY_WIDTH-1:0]    o__enqueue_priority,
    output PacketPointer                 o__packet_pointer,
    input  logic                         i__pifo_full,
    input  logic                         i__dequeue_fire,
    input  logic [PRIORITY_WIDTH-1:0]    i__dequeue_priority,
`ifdef FLOW_RANK_WEIGHT_EN
    input  logic                         i__weight_wr,
    input  logic [$clog2(NUM_FLOWS)-1:0] i__weight_flow_id,
    input  logic [3:0]                   i__weight_shift,
`endif
    output logic [PRIORITY_WIDTH-1:0]    o__virtual_time
);

    localparam int FLOW_W  = $clog2(NUM_FLOWS);
    localparam int SHIFT_W = LENGTH_WIDTH + 15;   // room for length << 15

    // S1 stage
    logic                      r_s1_valid;
    logic [FLOW_W-1:0]         r_s1_flow;
    logic [LENGTH_WIDTH-1:0]   r_s1_len;
    PacketPointer              r_s1_ptr;

    // OUT stage
    logic                      r_out_valid;
    logic [PRIORITY_WIDTH-1:0] r_out_prio;
    PacketPointer              r_out_ptr;

    logic [PRIORITY_WIDTH-1:0] r_vtime;

    logic                      w_out_drain;
    logic                      w_s1_advance;
    logic                      w_accept;
    logic [PRIORITY_WIDTH-1:0] w_finish_rd;
    logic [PRIORITY_WIDTH-1:0] w_start;
    logic [PRIORITY_WIDTH-1:0] w_cost;
    logic [PRIORITY_WIDTH:0]   w_sum;
    logic [PRIORITY_WIDTH-1:0] w_finish_next;

    assign w_out_drain  = r_out_valid & ~i__pifo_full;
    assign w_s1_advance = r_s1_valid & (~r_out_valid | w_out_drain);
    assign o__pkt_ready = ~r_s1_valid | w_s1_advance;
    assign w_accept     = i__pkt_valid & o__pkt_ready;

    // Rank uses the registered virtual time, so a dequeue reported in the
    // same cycle only influences packets ranked afterwards.
    assign w_start = (w_finish_rd > r_vtime) ? w_finish_rd : r_vtime;

`ifdef FLOW_RANK_WEIGHT_EN
    logic [3:0]         w_weight;
    logic [SHIFT_W-1:0] w_shifted;

    assign w_shifted = {15'b0, r_s1_len} << w_weight;
    assign w_cost    = (w_shifted > SHIFT_W'({PRIORITY_WIDTH{1'b1}}))
                       ? '1 : w_shifted[PRIORITY_WIDTH-1:0];
`else
    assign w_cost = PRIORITY_WIDTH'(r_s1_len);
`endif

    // Finish tags clamp at all-ones; a wrapped tag would jump the queue.
    assign w_sum         = (PRIORITY_WIDTH+1)'(w_start) + (PRIORITY_WIDTH+1)'(w_cost);
    assign w_finish_next = w_sum[PRIORITY_WIDTH] ? '1 : w_sum[PRIORITY_WIDTH-1:0];

    stfq_flow_table #(
        .NUM_FLOWS      (NUM_FLOWS),
        .PRIORITY_WIDTH (PRIORITY_WIDTH),
        .FLOW_WIDTH     (FLOW_W)
    ) u_flow_table (
        .clk               (clk),
        .reset             (reset),
        .i__rd_flow_id     (r_s1_flow),
        .i__wr_en          (w_s1_advance),
        .i__wr_flow_id     (r_s1_flow),
        .i__wr_finish      (w_finish_next),
`ifdef FLOW_RANK_WEIGHT_EN
        .i__weight_wr      (i__weight_wr),
        .i__weight_flow_id (i__weight_flow_id),
        .i__weight_shift   (i__weight_shift),
        .o__rd_weight      (w_weight),
`endif
        .o__rd_finish      (w_finish_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_flow   <= '0;
            r_s1_len    <= '0;
            r_s1_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_prio  <= '0;
            r_out_ptr   <= '0;
            r_vtime     <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_flow  <= i__pkt_flow_id;
                r_s1_len   <= i__pkt_length;
                r_s1_ptr   <= i__pkt_pointer;
            end else if (w_s1_advance) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_advance) begin
                r_out_valid <= 1'b1;
                r_out_prio  <= w_start;
                r_out_ptr   <= r_s1_ptr;
            end else if (w_out_drain) begin
                r_out_valid <= 1'b0;
            end

            if (i__dequeue_fire && (i__dequeue_priority > r_vtime)) begin
                r_vtime <= i__dequeue_priority;
            end
        end
    end

    assign o__enqueue          = w_out_drain;
    assign o__enqueue_priority = r_out_prio;
    assign o__packet_pointer   = r_out_ptr;
    assign o__virtual_time     = r_vtime;

endmodule

`default_nettype wire

// File: tb/tb_stfq_rank_calc.sv
// ============================================================================
//  Module      : tb_stfq_rank_calc
//  Description : Self-checking bench for stfq_rank_calc. Directed scenarios
//                followed by randomized bursts scored against a
//                transaction-level STFQ model (per-flow finish tags,
//                virtual time, expected enqueue order).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stfq_rank_calc;

    localparam int NF = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [5:0]  pkt_flow = '0;
    logic [10:0] pkt_len = '0;
    logic [11:0] pkt_ptr = '0;
    logic        pkt_ready;
    logic        enq;
    logic [15:0] enq_prio;
    logic [11:0] enq_ptr;
    logic        pifo_full = 1'b0;
    logic        dq_fire = 1'b0;
    logic [15:0] dq_prio = '0;
    logic [15:0] vtime;
`ifdef FLOW_RANK_WEIGHT_EN
    logic        wt_wr = 1'b0;
    logic [5:0]  wt_flow = '0;
    logic [3:0]  wt_shift = '0;
`endif

    always #5 clk = ~clk;

    stfq_rank_calc dut (
        .clk                 (clk),
        .reset               (reset),
        .i__pkt_valid        (pkt_valid),
        .i__pkt_flow_id      (pkt_flow),
        .i__pkt_length       (pkt_len),
        .i__pkt_pointer      (pkt_ptr),
        .o__pkt_ready        (pkt_ready),
        .o__enqueue          (enq),
        .o__enqueue_priority (enq_prio),
        .o__packet_pointer   (enq_ptr),
        .i__pifo_full        (pifo_full),
        .i__dequeue_fire     (dq_fire),
        .i__dequeue_priority (dq_prio),
`ifdef FLOW_RANK_WEIGHT_EN
        .i__weight_wr        (wt_wr),
        .i__weight_flow_id   (wt_flow),
        .i__weight_shift     (wt_shift),
`endif
        .o__virtual_time     (vtime)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned prio;
        int unsigned ptr;
    } ent_t;

    int unsigned m_finish [NF];
    int unsigned m_weight [NF];
    int unsigned m_vt;
    ent_t        exp_q[$];
    ent_t        obs_log[$];
    bit          rand_full = 1'b0;

    function automatic void model_reset();
        for (int i = 0; i < NF; i++) begin
            m_finish[i] = 0;
            m_weight[i] = 0;
        end
        m_vt = 0;
        exp_q.delete();
        obs_log.delete();
    endfunction

    // Packets are ranked in arrival order; start = max(vt, last finish).
    function automatic void model_accept(input int f, input int len, input int ptr);
        int unsigned start, cost, fin;
        ent_t e;
        start = (m_finish[f] > m_vt) ? m_finish[f] : m_vt;
        cost  = int'(len) << m_weight[f];
        if (cost > 32'hFFFF) cost = 32'hFFFF;
        fin = start + cost;
        if (fin > 32'hFFFF) fin = 32'hFFFF;
        m_finish[f] = fin;
        e.prio = start;
        e.ptr  = ptr & 32'hFFF;
        exp_q.push_back(e);
    endfunction

    // ---------------- enqueue monitor ----------------
    always @(negedge clk) begin
        ent_t o, e;
        if (!reset && enq) begin
            o.prio = enq_prio;
            o.ptr  = enq_ptr;
            obs_log.push_back(o);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_enqueue", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("enq_prio", enq_prio, e.prio);
                check_eq("enq_ptr", enq_ptr, e.ptr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int f, input int len, input int ptr);
        int budget = 0;
        bit took = 1'b0;
        pkt_valid = 1'b1;
        pkt_flow  = 6'(f);
        pkt_len   = 11'(len);
        pkt_ptr   = 12'(ptr);
        while (!took && budget < 200) begin
            @(negedge clk);
            if (pkt_ready) begin
                took = 1'b1;
                model_accept(f, len, ptr);
            end
            tick();
            if (rand_full) pifo_full = ($urandom_range(0, 99) < 40);
            budget++;
        end
        if (!took) check_eq("send_timeout", 32'd0, 32'd1);
        pkt_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        pkt_valid = 1'b0;
        pifo_full = 1'b0;
        while (exp_q.size() != 0 && b < 300) begin
            tick();
            b++;
        end
        check_eq("drain_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        check_eq("drain_enq_idle", enq, 32'd0);
        tick();
    endtask

    task automatic deq(input int p);
        dq_fire = 1'b1;
        dq_prio = 16'(p);
        tick();
        dq_fire = 1'b0;
        if (p > int'(m_vt)) m_vt = p;
        check_eq("vtime", vtime, m_vt);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pkt_valid = 1'b0;
        pifo_full = 1'b0;
        dq_fire   = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_log(input string tag, input int idx, input int exp);
        logic [31:0] got;
        got = (obs_log.size() > idx) ? obs_log[idx].prio : 32'hDEAD_BEEF;
        check_eq(tag, got, exp);
    endtask

`ifdef FLOW_RANK_WEIGHT_EN
    task automatic set_weight(input int f, input int s);
        wt_wr    = 1'b1;
        wt_flow  = 6'(f);
        wt_shift = 4'(s);
        tick();
        wt_wr = 1'b0;
        m_weight[f] = s;
    endtask
`endif

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int k;
        int ptr_ctr;
        int lens [3];
        lens[0] = 10;
        lens[1] = 20;
        lens[2] = 30;

        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("rst_enqueue", enq, 32'd0);
        check_eq("rst_prio", enq_prio, 32'd0);
        check_eq("rst_ptr", enq_ptr, 32'd0);
        check_eq("rst_vtime", vtime, 32'd0);
        check_eq("rst_ready", pkt_ready, 32'd1);
        tick();

        // Single flow, with two-cycle latency check on the first packet
        send(0, 100, 1);
        @(negedge clk);
        check_eq("latency_e1", enq, 32'd0);
        tick();
        @(negedge clk);
        check_eq("latency_e2", enq, 32'd1);
        tick();
        send(0, 200, 2);
        send(0, 1, 3);
        drain();
        check_eq("single_count", obs_log.size(), 32'd3);
        check_log("single_p0", 0, 0);
        check_log("single_p1", 1, 100);
        check_log("single_p2", 2, 300);

        // Two interleaved flows
        do_reset();
        send(1, 50, 10);
        send(2, 50, 11);
        send(1, 50, 12);
        send(2, 50, 13);
        drain();
        check_log("inter_p0", 0, 0);
        check_log("inter_p1", 1, 0);
        check_log("inter_p2", 2, 50);
        check_log("inter_p3", 3, 50);

        // Back-pressure: 5 full cycles, 3 descriptors offered
        do_reset();
        pifo_full = 1'b1;
        acc = 0;
        k = 0;
        pkt_valid = 1'b1;
        pkt_flow  = 6'd4;
        pkt_len   = 11'(lens[0]);
        pkt_ptr   = 12'd20;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (pkt_ready && k < 3) begin
                model_accept(4, lens[k], 20 + k);
                acc++;
                k++;
            end
            tick();
            if (k < 3) begin
                pkt_len = 11'(lens[k]);
                pkt_ptr = 12'(20 + k);
            end
        end
        check_eq("stall_accepted", acc, 32'd2);
        @(negedge clk);
        check_eq("stall_ready", pkt_ready, 32'd0);
        check_eq("stall_enq", enq, 32'd0);
        check_eq("stall_out_prio", enq_prio, 32'd0);
        check_eq("stall_out_ptr", enq_ptr, 32'd20);
        tick();
        pifo_full = 1'b0;
        send(4, lens[2], 22);
        drain();
        check_eq("stall_count", obs_log.size(), 32'd3);
        check_log("stall_p0", 0, 0);
        check_log("stall_p1", 1, 10);
        check_log("stall_p2", 2, 30);

        // Virtual time from dequeues
        do_reset();
        send(3, 100, 30);
        drain();
        deq(500);
        send(3, 10, 31);
        drain();
        check_log("vt_rank", 1, 500);
        deq(200);
        check_eq("vt_monotonic", vtime, 32'd500);

        // Saturation
        do_reset();
        deq(16'hFFF0);
        send(0, 16'h40, 40);
        send(0, 5, 41);
        drain();
        check_log("sat_p0", 0, 16'hFFF0);
        check_log("sat_p1", 1, 16'hFFFF);

        // Dequeue in the same cycle as the rank: old virtual time is used
        do_reset();
        pkt_valid = 1'b1;
        pkt_flow  = 6'd7;
        pkt_len   = 11'd5;
        pkt_ptr   = 12'd50;
        @(negedge clk);
        check_eq("coinc_ready", pkt_ready, 32'd1);
        model_accept(7, 5, 50);
        tick();
        pkt_valid = 1'b0;
        dq_fire   = 1'b1;
        dq_prio   = 16'd1000;
        tick();
        dq_fire = 1'b0;
        m_vt = 1000;
        check_eq("coinc_vtime", vtime, 32'd1000);
        send(7, 5, 51);
        drain();
        check_log("coinc_p0", 0, 0);
        check_log("coinc_p1", 1, 1000);

        // Reset asserted mid-stall
        pifo_full = 1'b1;
        send(9, 100, 60);
        send(9, 100, 61);
        reset = 1'b1;
        #1;
        check_eq("midrst_enq", enq, 32'd0);
        check_eq("midrst_prio", enq_prio, 32'd0);
        check_eq("midrst_ptr", enq_ptr, 32'd0);
        check_eq("midrst_vtime", vtime, 32'd0);
        model_reset();
        pifo_full = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check_eq("midrst_ready", pkt_ready, 32'd1);
        tick();
        send(9, 100, 62);
        drain();
        check_eq("midrst_count", obs_log.size(), 32'd1);
        check_log("midrst_p0", 0, 0);

`ifdef FLOW_RANK_WEIGHT_EN
        do_reset();
        set_weight(5, 2);
        send(5, 64, 70);
        send(5, 64, 71);
        drain();
        check_log("weight_p0", 0, 0);
        check_log("weight_p1", 1, 256);
`endif

        // Randomized bursts with random back-pressure, then dequeues
        do_reset();
        ptr_ctr = 100;
        for (int r = 0; r < 25; r++) begin
`ifdef FLOW_RANK_WEIGHT_EN
            if ($urandom_range(0, 2) == 0) set_weight($urandom_range(0, 7), $urandom_range(0, 6));
`endif
            rand_full = 1'b1;
            for (int j = 0, n = $urandom_range(1, 12); j < n; j++) begin
                send($urandom_range(0, 7), $urandom_range(0, 2047), ptr_ctr);
                ptr_ctr++;
            end
            rand_full = 1'b0;
            drain();
            for (int d = 0, n = $urandom_range(0, 3); d < n; d++) begin
                int p;
                if ($urandom_range(0, 3) == 0) p = $urandom_range(0, m_vt);
                else p = int'(m_vt) + $urandom_range(0, 3000);
                if (p > 16'hFFFF) p = 16'hFFFF;
                deq(p);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/stfq_rank_calc.md
# stfq_rank_calc

Start-time fair queueing (STFQ) rank stage directly upstream of the flow-level PIFO. Accepts packet descriptors (flow id, length, packet pointer), keeps a per-flow last-finish-tag table and a global virtual time, and computes each packet's enqueue priority. It then presents the packet pointer and priority to the PIFO's enqueue port, honouring the PIFO's full flag. Virtual time advances from the priorities the PIFO dequeues.

## Interface
Parameters:
- NUM_FLOWS, 64, number of flows; flow id width is $clog2(NUM_FLOWS)
- PRIORITY_WIDTH, 16, width of rank, finish tags and virtual time; equals $bits(Priority)
- LENGTH_WIDTH, 11, packet length width in bytes

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i__pkt_valid  in  1  descriptor valid
- i__pkt_flow_id  in  $clog2(NUM_FLOWS)  flow of the descriptor
- i__pkt_length  in  LENGTH_WIDTH  packet length
- i__pkt_pointer  in  $bits(PacketPointer)  packet buffer pointer
- o__pkt_ready  out  1  descriptor accepted when valid & ready
- o__enqueue  out  1  enqueue strobe to the PIFO
- o__enqueue_priority  out  PRIORITY_WIDTH  computed start tag
- o__packet_pointer  out  $bits(PacketPointer)  pointer to the PIFO
- i__pifo_full  in  1  PIFO full
- i__dequeue_fire  in  1  PIFO pop performed this cycle
- i__dequeue_priority  in  PRIORITY_WIDTH  priority of the popped entry
- o__virtual_time  out  PRIORITY_WIDTH  current virtual time
- i__weight_wr, i__weight_flow_id, i__weight_shift[3:0]  in  weight programming; present only with FLOW_RANK_WEIGHT_EN

## Operation
- Two registers: S1 (accepted descriptor) and OUT (rank-computed entry awaiting the PIFO).
- Accept: o__pkt_ready = ~s1_valid | s1_advance. Descriptor is captured into S1 on valid & ready.
- s1_advance = s1_valid & (~out_valid | out_drain), where out_drain = out_valid & ~i__pifo_full.
- On s1_advance, in the same cycle:
  - F = finish[flow]
  - start = max(virtual_time, F), compared unsigned
  - cost = length (or length << weight[flow], per Configuration)
  - finish[flow] <= sat(start + cost); the sum saturates to all-ones and never wraps
  - OUT <= {start, pointer}, out_valid <= 1
- The table is written only on s1_advance, so a back-to-back packet of the same flow reads the updated tag. No bypass is required.
- o__enqueue = out_valid & ~i__pifo_full. out_valid clears on drain unless refilled in the same cycle.
- o__enqueue_priority and o__packet_pointer always reflect OUT.
- Virtual time: on i__dequeue_fire, virtual_time <= max(virtual_time, i__dequeue_priority). Virtual time is monotonic and never decreases.
- Simultaneous dequeue_fire and s1_advance: the rank uses the pre-update virtual_time.
- Reset (any time, including mid-operation):
  - s1_valid = 0, out_valid = 0
  - o__enqueue = 0, o__enqueue_priority = 0, o__packet_pointer = 0
  - o__virtual_time = 0
  - o__pkt_ready = 1 after reset deasserts
  - all finish tags = 0, all weights = 0
  - in-flight descriptors are dropped

## Timing
- Accepted at edge E0: o__enqueue is high in the cycle after E1 if the PIFO is not full. Latency is 2 cycles, throughput is 1 per cycle.
- While i__pifo_full is high, OUT holds stable, S1 holds, and o__pkt_ready = ~s1_valid. At most 2 descriptors are buffered.
- o__virtual_time updates the cycle after i__dequeue_fire.

## Configuration
- FLOW_RANK_WEIGHT_EN defined:
  - per-flow 4-bit shift table; weight write updates weight[i__weight_flow_id] on i__weight_wr
  - cost = length << weight, saturating to PRIORITY_WIDTH
  - a write that coincides with s1_advance for the same flow takes effect on the next packet
- Not defined: weight ports are absent and cost = length.

## Structure
- pifo_headers package holds Priority, PacketPointer, FlowId, PacketLength, NUM_FLOWS, and a sat_add function.
- One sub-module, stfq_flow_table:
  - NUM_FLOWS x PRIORITY_WIDTH finish tags (plus weights when enabled)
  - one async read port, one write port
  - async reset to 0

## Test plan
- Single flow 0: lengths 100 then 200 with virtual_time 0 -> priorities 0, then 100; finish[0] = 300.
- Two flows interleaved, flow 1 length 50, flow 2 length 50 -> both priority 0; second packets priority 50 each.
- i__pifo_full held high for 5 cycles with 3 descriptors offered -> 2 accepted, o__pkt_ready low, OUT stable. After release, priorities are emitted in order with no loss or duplication.
- i__dequeue_fire with priority 500, then flow 3 packet whose finish tag is 100 -> priority 500. A later dequeue with priority 200 leaves virtual_time at 500.
- Saturation: finish[0] = 0xFFF0, length 0x40 -> finish saturates to 0xFFFF. Next priority = 0xFFFF.
- With FLOW_RANK_WEIGHT_EN, weight[5] = 2 and lengths 64, 64 -> priorities 0 and 256. Asserting reset mid-stall clears all outputs, tags, and virtual time.
